// File: rtl/spmmio_sdspi.sv
// spmmio_sdspi: SPI-mode (mode 0, MSB first) byte engine for the SD card slot.
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   adr, cs, sel, we, d register window (big-endian numbering, bit 31 = LSB)
//   q                  combinational read data selected by adr
//   sdcard_cs          card chip select pin, low = selected (= ~cs_en)
//   sdcard_sck         SPI clock, idles low
//   sdcard_miso        card data out, registered before use
//   sdcard_mosi        card data in, idles high
//
// Register map (word address):
//   0 CTRL/STAT  q[28]=cs_en q[29]=done q[31]=busy; write d[28]=cs_en, d[29]=1 clears done
//   1 DIV        q[24:31]=div; each SCK phase lasts div+1 clks
//   2 DATA       read rx byte; write starts a transfer when idle
module spmmio_sdspi #(
    parameter logic [7:0] DIV_RESET = 8'd63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:3]  adr,
    input  logic        cs,
    input  logic [0:3]  sel,
    input  logic        we,
    input  logic [0:31] d,
    output logic [0:31] q,
    output logic        sdcard_cs,
    output logic        sdcard_sck,
    input  logic        sdcard_miso,
    output logic        sdcard_mosi
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] phase_r, phase_s;
    logic [2:0] bit_r, bit_s;
    logic [7:0] tx_r, tx_s;
    logic [7:0] shift_r, shift_s;
    logic [7:0] rx_r, rx_s;
    logic [7:0] div_l_r, div_l_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       sck_r, sck_s;
    logic       mosi_r, mosi_s;
    logic       done_set_s;
    logic [7:0] div_r;
    logic       cs_en_r;
    logic       miso_q_r;

    logic       wr_s, wr_ctrl_s, wr_div_s, wr_data_s, start_s;
    logic       unused_s;

    // Only byte lane 3 carries writable bits; the upper data bits are don't-care.
    assign unused_s  = ^{sel[0:2], d[0:23]};

    assign wr_s      = cs & we & sel[3];
    assign wr_ctrl_s = wr_s & (adr == 4'd0);
    assign wr_div_s  = wr_s & (adr == 4'd1);
    assign wr_data_s = wr_s & (adr == 4'd2);
    // A DATA write while busy is dropped on the floor.
    assign start_s   = wr_data_s & ~busy_r;

    assign sdcard_cs   = ~cs_en_r;
    assign sdcard_sck  = sck_r;
    assign sdcard_mosi = mosi_r;

    // Software-visible configuration registers and the MISO input flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r    <= DIV_RESET;
            cs_en_r  <= 1'b0;
            miso_q_r <= 1'b1;
        end else begin
            miso_q_r <= sdcard_miso;
            if (wr_div_s) begin
                div_r <= d[24:31];
            end else begin
                div_r <= div_r;
            end
            if (wr_ctrl_s) begin
                cs_en_r <= d[28];
            end else begin
                cs_en_r <= cs_en_r;
            end
        end
    end

    // Transfer state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            phase_r <= 8'd0;
            bit_r   <= 3'd0;
            tx_r    <= 8'd0;
            shift_r <= 8'd0;
            rx_r    <= 8'hFF;
            div_l_r <= 8'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sck_r   <= 1'b0;
            mosi_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
            bit_r   <= bit_s;
            tx_r    <= tx_s;
            shift_r <= shift_s;
            rx_r    <= rx_s;
            div_l_r <= div_l_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            sck_r   <= sck_s;
            mosi_r  <= mosi_s;
        end
    end

    // Next-state logic: phase counter times each SCK half period of div_l+1 clks.
    always_comb begin
        state_s    = state_r;
        phase_s    = phase_r;
        bit_s      = bit_r;
        tx_s       = tx_r;
        shift_s    = shift_r;
        rx_s       = rx_r;
        div_l_s    = div_l_r;
        busy_s     = busy_r;
        sck_s      = sck_r;
        mosi_s     = mosi_r;
        done_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sck_s = 1'b0;
                if (start_s) begin
                    state_s = ST_LOW;
                    tx_s    = d[24:31];
                    div_l_s = div_r;
                    bit_s   = 3'd7;
                    phase_s = 8'd0;
                    busy_s  = 1'b1;
                    mosi_s  = d[24];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (phase_r == div_l_r) begin
                    state_s = ST_HIGH;
                    phase_s = 8'd0;
                    sck_s   = 1'b1;
                end else begin
                    phase_s = phase_r + 8'd1;
                end
            end
            ST_HIGH: begin
                if (phase_r == div_l_r) begin
                    // Last clk of the high phase: sample, then drop SCK.
                    shift_s = {shift_r[6:0], miso_q_r};
                    phase_s = 8'd0;
                    sck_s   = 1'b0;
                    if (bit_r != 3'd0) begin
                        bit_s   = bit_r - 3'd1;
                        tx_s    = {tx_r[6:0], 1'b0};
                        mosi_s  = tx_r[6];
                        state_s = ST_LOW;
                    end else begin
                        state_s    = ST_IDLE;
                        rx_s       = {shift_r[6:0], miso_q_r};
                        busy_s     = 1'b0;
                        mosi_s     = 1'b1;
                        done_set_s = 1'b1;
                    end
                end else begin
                    phase_s = phase_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                sck_s   = 1'b0;
                mosi_s  = 1'b1;
            end
        endcase
        // Completion takes priority over a same-clk clear.
        if (done_set_s) begin
            done_s = 1'b1;
        end else if (start_s || (wr_ctrl_s && d[29])) begin
            done_s = 1'b0;
        end else begin
            done_s = done_r;
        end
    end

    // Read mux.
    always_comb begin
        q = 32'd0;
        case (adr)
            4'd0: begin
                q[28] = cs_en_r;
                q[29] = done_r;
                q[31] = busy_r;
            end
            4'd1:    q[24:31] = div_r;
            4'd2:    q[24:31] = rx_r;
            default: q = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_spmmio_sdspi.sv
module tb_spmmio_sdspi;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:3]  adr;
    logic        cs;
    logic [0:3]  sel;
    logic        we;
    logic [0:31] d;
    logic [0:31] q;
    logic        sdcard_cs;
    logic        sdcard_sck;
    logic        sdcard_miso;
    logic        sdcard_mosi;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spmmio_sdspi #(.DIV_RESET(8'd63)) dut (
        .clk(clk), .reset(reset), .adr(adr), .cs(cs), .sel(sel), .we(we),
        .d(d), .q(q), .sdcard_cs(sdcard_cs), .sdcard_sck(sdcard_sck),
        .sdcard_miso(sdcard_miso), .sdcard_mosi(sdcard_mosi)
    );

    // Expected serial transfers: byte on MOSI and SCK half period in clks.
    typedef struct {
        logic [7:0] tx;
        int         per;
    } xfer_t;
    xfer_t exp_q[$];

    // Card model: either loopback, or a slave shifting a byte out on SCK falls.
    logic       loop_en;
    logic [7:0] slave_byte;
    int         sidx;
    always @(negedge sdcard_sck) sidx = sidx + 1;
    assign sdcard_miso = loop_en ? sdcard_mosi :
                         (sidx < 8 ? slave_byte[3'(7 - sidx)] : 1'b1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pin monitor: reassembles each MOSI byte and measures SCK phase lengths.
    int    m_bitn = 0, m_hl = 0, m_ll = 0;
    logic  m_sck_p = 1'b0;
    logic [7:0] m_shift = 8'd0;
    xfer_t m_cur;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_bitn  = 0;
            m_hl    = 0;
            m_ll    = 0;
            m_sck_p = 1'b0;
        end else begin
            if (sdcard_sck) begin
                if (!m_sck_p) begin
                    if (m_bitn == 0) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_sck", 32'd1, 32'd0);
                            m_cur = '{8'd0, 0};
                        end else begin
                            m_cur = exp_q[0];
                        end
                    end else begin
                        chk("sck_low_len", 32'(m_ll), 32'(m_cur.per));
                    end
                    m_shift = {m_shift[6:0], sdcard_mosi};
                    m_hl = 1;
                end else begin
                    m_hl++;
                end
            end else begin
                if (m_sck_p) begin
                    chk("sck_high_len", 32'(m_hl), 32'(m_cur.per));
                    m_bitn++;
                    m_ll = 1;
                    if (m_bitn == 8) begin
                        chk("mosi_byte", {24'd0, m_shift}, {24'd0, m_cur.tx});
                        if (exp_q.size() != 0) void'(exp_q.pop_front());
                        m_bitn = 0;
                    end
                end else begin
                    m_ll++;
                end
            end
            m_sck_p = sdcard_sck;
        end
    end

    function automatic logic [0:31] byte_w(input logic [7:0] b);
        logic [0:31] r;
        r = 32'd0;
        r[24:31] = b;
        return r;
    endfunction

    function automatic logic [0:31] ctrl_w(input logic cs_en, input logic clr);
        logic [0:31] r;
        r = 32'd0;
        r[28] = cs_en;
        r[29] = clr;
        return r;
    endfunction

    task automatic wr(input logic [3:0] a, input logic [0:31] v);
        @(negedge clk);
        adr = a; d = v; cs = 1'b1; we = 1'b1; sel = 4'b1111;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0; d = 32'd0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [0:31] v);
        @(negedge clk);
        adr = a;
        #1;
        v = q;
    endtask

    task automatic start(input logic [7:0] tx, input int div, input logic loop,
                         input logic [7:0] sb, output logic [7:0] exp_rx);
        loop_en    = loop;
        slave_byte = sb;
        sidx       = 0;
        exp_q.push_back('{tx, div + 1});
        exp_rx = loop ? tx : sb;
        wr(4'd2, byte_w(tx));
    endtask

    // Counts clks with busy high, starting just after the start edge.
    task automatic wait_idle(output int n);
        logic [0:31] v;
        n = 0;
        rd(4'd0, v);
        while (v[31] && n < 5000) begin
            n++;
            rd(4'd0, v);
        end
        if (n >= 5000) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_done(input string name, input logic [7:0] exp_rx);
        logic [0:31] v;
        rd(4'd2, v);
        chk({name, "_rx"}, {24'd0, v[24:31]}, {24'd0, exp_rx});
        rd(4'd0, v);
        chk({name, "_done"}, {31'd0, v[29]}, 32'd1);
        chk({name, "_busy"}, {31'd0, v[31]}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:31] v;
        logic [7:0]  erx, prev_rx, tx, sb;
        int          n, dv;
        logic        lp;

        reset = 1'b1; cs = 1'b0; we = 1'b0; sel = 4'b0000; adr = 4'd0; d = 32'd0;
        loop_en = 1'b1; slave_byte = 8'hFF; sidx = 8;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sdcard_cs", {31'd0, sdcard_cs}, 32'd1);
        chk("rst_sck", {31'd0, sdcard_sck}, 32'd0);
        chk("rst_mosi", {31'd0, sdcard_mosi}, 32'd1);
        rd(4'd0, v); chk("rst_ctrl", v, 32'd0);
        rd(4'd1, v); chk("rst_div", v, 32'd63);
        rd(4'd2, v); chk("rst_rx", v, 32'hFF);
        rd(4'd5, v); chk("rst_unmapped", v, 32'd0);
        @(negedge clk); reset = 1'b0;

        // Loopback at the fastest rate.
        wr(4'd1, byte_w(8'd0));
        start(8'hA5, 0, 1'b1, 8'h00, erx);
        wait_idle(n);
        chk("loop_busy_len", 32'(n), 32'd16);
        chk_done("loop", erx);

        // div=3 against a card driving all zeros, then all ones.
        wr(4'd1, byte_w(8'd3));
        start(8'h3C, 3, 1'b0, 8'h00, erx);
        wait_idle(n);
        chk("div3_busy_len", 32'(n), 32'd64);
        chk_done("div3_zero", erx);
        start(8'h3C, 3, 1'b0, 8'hFF, erx);
        wait_idle(n);
        chk("div3b_busy_len", 32'(n), 32'd64);
        chk_done("div3_ones", erx);
        prev_rx = erx;

        // DATA and DIV writes during a transfer.
        sb = 8'($urandom);
        start(8'h81, 3, 1'b0, sb, erx);
        repeat (10) @(posedge clk);
        wr(4'd2, byte_w(8'h7E));
        wr(4'd1, byte_w(8'd0));
        rd(4'd1, v); chk("div_mid_write", {24'd0, v[24:31]}, 32'd0);
        rd(4'd2, v); chk("rx_mid_xfer", {24'd0, v[24:31]}, {24'd0, prev_rx});
        wait_idle(n);
        chk_done("busy_prot", erx);
        start(8'h6D, 0, 1'b1, 8'h00, erx);
        wait_idle(n);
        chk("new_div_busy_len", 32'(n), 32'd16);
        chk_done("new_div", erx);

        // done clear on the completion clk: set wins.
        start(8'hC3, 0, 1'b1, 8'h00, erx);
        repeat (15) @(posedge clk);
        wr(4'd0, ctrl_w(1'b0, 1'b1));
        rd(4'd0, v);
        chk("done_set_wins", {31'd0, v[29]}, 32'd1);
        chk("done_set_busy", {31'd0, v[31]}, 32'd0);
        // New start clears done; clear one clk after completion sticks.
        start(8'h18, 0, 1'b1, 8'h00, erx);
        rd(4'd0, v);
        chk("start_clears_done", {31'd0, v[29]}, 32'd0);
        chk("start_sets_busy", {31'd0, v[31]}, 32'd1);
        repeat (16) @(posedge clk);
        wr(4'd0, ctrl_w(1'b0, 1'b1));
        rd(4'd0, v);
        chk("done_cleared", {31'd0, v[29]}, 32'd0);
        rd(4'd2, v);
        chk("done_test_rx", {24'd0, v[24:31]}, {24'd0, erx});

        // Chip select control, including a deselect mid-transfer.
        chk("cs_before", {31'd0, sdcard_cs}, 32'd1);
        wr(4'd0, ctrl_w(1'b1, 1'b0));
        chk("cs_selected", {31'd0, sdcard_cs}, 32'd0);
        wr(4'd1, byte_w(8'd1));
        sb = 8'($urandom);
        start(8'h96, 1, 1'b0, sb, erx);
        repeat (8) @(posedge clk);
        wr(4'd0, ctrl_w(1'b0, 1'b0));
        chk("cs_deselect_mid", {31'd0, sdcard_cs}, 32'd1);
        wait_idle(n);
        chk_done("cs_mid", erx);

        // Randomized transfers.
        for (int i = 0; i < 12; i++) begin
            dv = int'($urandom_range(0, 3));
            tx = 8'($urandom);
            sb = 8'($urandom);
            lp = 1'($urandom);
            wr(4'd1, byte_w(8'(dv)));
            start(tx, dv, lp, sb, erx);
            wait_idle(n);
            chk("rand_busy_len", 32'(n), 32'(16 * (dv + 1)));
            chk_done("rand", erx);
        end

        // Reset in the middle of a high SCK phase.
        wr(4'd0, ctrl_w(1'b1, 1'b0));
        wr(4'd1, byte_w(8'd2));
        start(8'h5A, 2, 1'b1, 8'h00, erx);
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_sck", {31'd0, sdcard_sck}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_sck", {31'd0, sdcard_sck}, 32'd0);
        chk("arst_mosi", {31'd0, sdcard_mosi}, 32'd1);
        chk("arst_cs", {31'd0, sdcard_cs}, 32'd1);
        rd(4'd0, v); chk("arst_ctrl", v, 32'd0);
        rd(4'd1, v); chk("arst_div", v, 32'd63);
        rd(4'd2, v); chk("arst_rx", v, 32'hFF);
        @(negedge clk); reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("arst_stays_idle_sck", {31'd0, sdcard_sck}, 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
